preg_free_list: RTL and testbench
=================================

Name: preg_free_list

Overview:
- Circular free list of physical register tags.
- Supplies up to two new destination tags per cycle to rename, and reclaims up to two stale tags per cycle from commit.
- Its tags are the write-back addresses later used on the physical register file write ports and as rename source addresses.
- Keeps a speculative head and a committed head so that a pipeline flush reclaims all uncommitted allocations in one cycle.

Parameters:
- REG_SIZE, 64, number of physical registers; power of two; P0 is hard-wired zero and never allocated.
- REG_SIZE_WIDTH, 6, log2(REG_SIZE); width of a tag.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- alloc_first_i  input  1  rename consumes a tag for instruction slot 0
- alloc_second_i  input  1  rename consumes a tag for instruction slot 1
- prd_first_o  output  REG_SIZE_WIDTH  tag offered to slot 0
- prd_second_o  output  REG_SIZE_WIDTH  tag offered to slot 1
- alloc_ok_o  output  1  at least two tags available
- free_count_o  output  REG_SIZE_WIDTH+1  number of tags in the speculative list
- cmt_alloc_first_i  input  1  committing slot 0 had allocated a tag
- cmt_alloc_second_i  input  1  committing slot 1 had allocated a tag
- free_first_valid_i  input  1  return free_first_prd_i to the list
- free_first_prd_i  input  REG_SIZE_WIDTH  stale tag from commit slot 0
- free_second_valid_i  input  1  return free_second_prd_i to the list
- free_second_prd_i  input  REG_SIZE_WIDTH  stale tag from commit slot 1
- flush_i  input  1  discard all uncommitted allocations

Behaviour:
- Storage: REG_SIZE entries of REG_SIZE_WIDTH bits. Pointers are REG_SIZE_WIDTH+1 bits wide: spec_head, cmt_head, tail. Index = low REG_SIZE_WIDTH bits.
- free_count_o = tail - spec_head, modulo 2^(REG_SIZE_WIDTH+1). Maximum value is REG_SIZE-1.
- Reset:
  - entry[i] = i+1 for i = 0..REG_SIZE-2; entry[REG_SIZE-1] = 0.
  - spec_head = cmt_head = 0; tail = REG_SIZE-1.
  - Resulting outputs: free_count_o = 63, prd_first_o = 1, prd_second_o = 2, alloc_ok_o = 1.
  - Reset mid-operation discards all state and returns to these values.
- Offer (combinational from registers):
  - prd_first_o = entry[spec_head].
  - prd_second_o = alloc_first_i ? entry[spec_head+1] : entry[spec_head].
  - alloc_ok_o = (free_count_o >= 2).
- Allocate:
  - pops = alloc_first_i + alloc_second_i; spec_head advances by pops at posedge.
  - Requests when alloc_ok_o = 0 are ignored: no pointer change. Rename must stall.
- Free (pushes):
  - Each valid free with a non-zero tag is written at tail, first slot before second. tail advances by the number written.
  - A free of tag 0 is dropped. If only the second slot is valid, it writes at tail.
- Commit: cmt_head advances by cmt_alloc_first_i + cmt_alloc_second_i.
- Simultaneous allocate and free: both take effect. A tag freed this cycle is not visible on prd_*_o until the next cycle (no bypass).
  - free_count_next = free_count - pops + pushes.
- Flush:
  - spec_head <= cmt_head + this cycle's commit advance. Allocations in the flush cycle are ignored.
  - Frees and commits in the flush cycle still apply.
  - free_count_o becomes valid the following cycle.
- Invariant, checked by a bench assertion: free_count_o never exceeds REG_SIZE-1. Exceeding it indicates a double free; behaviour is undefined.
- Wrap-around: all pointer arithmetic is modulo 2^(REG_SIZE_WIDTH+1). Entry index wraps at REG_SIZE.

Test Plan:
- Reset release → prd_first_o = 1, prd_second_o = 2, free_count_o = 63, alloc_ok_o = 1.
- alloc_first_i = alloc_second_i = 1 for 31 cycles → tags 1..62 handed out in order. Then free_count_o = 1, alloc_ok_o = 0, prd_first_o = 63. A further dual request leaves free_count_o = 1.
- From the drained state: free tags 5 and 9 in one cycle while alloc is requested and ignored → next cycle free_count_o = 3. Next dual allocation yields 63 then 5; the following one yields 9, plus a tag freed later.
- Allocate 4 tags (1..4), commit 2 of them (cmt_alloc_first/second = 1), flush_i = 1 → next cycle prd_first_o = 3, free_count_o = 61.
- Flush in the same cycle as a dual alloc and a cmt_alloc_first_i → allocation ignored, spec_head = old cmt_head + 1.
- free_first_valid_i with tag 0 plus free_second_valid_i with tag 12 → only 12 is pushed; free_count_o rises by 1.
- Run more than 200 alloc/free cycles so the pointers wrap past REG_SIZE → FIFO order is preserved and free_count_o matches a reference-model count.

Source files
------------

// File: rtl/preg_free_list.sv
// ---------------------------------------------------------------------------
// preg_free_list
//
// Circular free list of physical register tags. Rename pulls up to two tags
// per cycle from the speculative head; commit returns up to two stale tags
// per cycle at the tail. A separate committed head lets a flush hand every
// uncommitted allocation back to the list in a single cycle, because the
// entries between cmt_head and spec_head are never overwritten while they
// are outstanding.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   alloc_first_i/second_i    rename consumes a tag for slot 0 / slot 1
//   prd_first_o/second_o      tags offered to slot 0 / slot 1
//   alloc_ok_o                at least two tags available
//   free_count_o              tags in the speculative list
//   cmt_alloc_first_i/second_i committing slot 0 / 1 had allocated a tag
//   free_*_valid_i/prd_i      stale tags returned by commit
//   flush_i                   discard all uncommitted allocations
// ---------------------------------------------------------------------------
module preg_free_list #(
    parameter int REG_SIZE       = 64,
    parameter int REG_SIZE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_first_i,
    input  logic                      alloc_second_i,
    output logic [REG_SIZE_WIDTH-1:0] prd_first_o,
    output logic [REG_SIZE_WIDTH-1:0] prd_second_o,
    output logic                      alloc_ok_o,
    output logic [REG_SIZE_WIDTH:0]   free_count_o,
    input  logic                      cmt_alloc_first_i,
    input  logic                      cmt_alloc_second_i,
    input  logic                      free_first_valid_i,
    input  logic [REG_SIZE_WIDTH-1:0] free_first_prd_i,
    input  logic                      free_second_valid_i,
    input  logic [REG_SIZE_WIDTH-1:0] free_second_prd_i,
    input  logic                      flush_i
);

    localparam int PW = REG_SIZE_WIDTH + 1;

    logic [REG_SIZE_WIDTH-1:0] entry [REG_SIZE];

    // One extra pointer bit distinguishes a full list from an empty one.
    logic [PW-1:0] spec_head;
    logic [PW-1:0] cmt_head;
    logic [PW-1:0] tail;

    logic [PW-1:0] free_count;
    logic [PW-1:0] spec_head_plus1;
    logic [PW-1:0] cmt_head_next;
    logic [PW-1:0] second_wr_ptr;
    logic [1:0]    pops;
    logic [1:0]    pushes;
    logic [1:0]    cmt_adv;
    logic          push_first;
    logic          push_second;
    logic          alloc_ok;

    assign free_count      = tail - spec_head;
    assign alloc_ok        = (free_count >= PW'(2));
    assign spec_head_plus1 = spec_head + PW'(1);

    assign free_count_o = free_count;
    assign alloc_ok_o   = alloc_ok;

    // Slot 1 takes the entry after slot 0's only if slot 0 actually consumes one.
    assign prd_first_o  = entry[spec_head[REG_SIZE_WIDTH-1:0]];
    assign prd_second_o = alloc_first_i ? entry[spec_head_plus1[REG_SIZE_WIDTH-1:0]]
                                        : entry[spec_head[REG_SIZE_WIDTH-1:0]];

    // Allocation is all-or-nothing gated by alloc_ok; rename stalls otherwise.
    // A flush cycle drops allocations since spec_head is being rewound.
    assign pops = (alloc_ok && !flush_i)
                  ? ({1'b0, alloc_first_i} + {1'b0, alloc_second_i})
                  : 2'd0;

    // Tag 0 is the hard-wired zero register and must never re-enter the list.
    assign push_first  = free_first_valid_i  && (free_first_prd_i  != '0);
    assign push_second = free_second_valid_i && (free_second_prd_i != '0);
    assign pushes      = {1'b0, push_first} + {1'b0, push_second};

    // The second free lands right after the first only if the first was kept.
    assign second_wr_ptr = push_first ? (tail + PW'(1)) : tail;

    assign cmt_adv       = {1'b0, cmt_alloc_first_i} + {1'b0, cmt_alloc_second_i};
    assign cmt_head_next = cmt_head + PW'(cmt_adv);

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_head <= '0;
            cmt_head  <= '0;
            tail      <= PW'(REG_SIZE - 1);
            // entry[i] = i+1; the last one truncates to 0, which is never
            // offered because tail stops one short of a full lap.
            for (int i = 0; i < REG_SIZE; i++) begin
                entry[i] <= REG_SIZE_WIDTH'(i + 1);
            end
        end else begin
            if (push_first) begin
                entry[tail[REG_SIZE_WIDTH-1:0]] <= free_first_prd_i;
            end
            if (push_second) begin
                entry[second_wr_ptr[REG_SIZE_WIDTH-1:0]] <= free_second_prd_i;
            end
            tail     <= tail + PW'(pushes);
            cmt_head <= cmt_head_next;
            // Rewind to the committed head including this cycle's commits.
            if (flush_i) begin
                spec_head <= cmt_head_next;
            end else begin
                spec_head <= spec_head + PW'(pops);
            end
        end
    end

endmodule

// File: tb/tb_preg_free_list.sv
// ---------------------------------------------------------------------------
// tb_preg_free_list
//
// Directed plus randomized bench for preg_free_list. The model keeps three
// tag queues: fl (speculative free list, front = next offered tag),
// uc (allocated, not yet committed, oldest first) and ret (committed tags
// that may later be returned as stale frees).
// ---------------------------------------------------------------------------
module tb_preg_free_list;

    localparam int RS = 64;
    localparam int W  = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         alloc_first_i = 1'b0;
    logic         alloc_second_i = 1'b0;
    logic [W-1:0] prd_first_o;
    logic [W-1:0] prd_second_o;
    logic         alloc_ok_o;
    logic [W:0]   free_count_o;
    logic         cmt_alloc_first_i = 1'b0;
    logic         cmt_alloc_second_i = 1'b0;
    logic         free_first_valid_i = 1'b0;
    logic [W-1:0] free_first_prd_i = '0;
    logic         free_second_valid_i = 1'b0;
    logic [W-1:0] free_second_prd_i = '0;
    logic         flush_i = 1'b0;

    preg_free_list #(.REG_SIZE(RS), .REG_SIZE_WIDTH(W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .alloc_first_i       (alloc_first_i),
        .alloc_second_i      (alloc_second_i),
        .prd_first_o         (prd_first_o),
        .prd_second_o        (prd_second_o),
        .alloc_ok_o          (alloc_ok_o),
        .free_count_o        (free_count_o),
        .cmt_alloc_first_i   (cmt_alloc_first_i),
        .cmt_alloc_second_i  (cmt_alloc_second_i),
        .free_first_valid_i  (free_first_valid_i),
        .free_first_prd_i    (free_first_prd_i),
        .free_second_valid_i (free_second_valid_i),
        .free_second_prd_i   (free_second_prd_i),
        .flush_i             (flush_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int fl[$];
    int uc[$];
    int ret[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        uc.delete();
        ret.delete();
        for (int i = 1; i < RS; i++) fl.push_back(i);
    endtask

    // Hold rst for two edges, then check the reset state while rst is still
    // high (alloc_first_i = 1 so slot 1 shows the second entry).
    task automatic do_reset();
        rst = 1'b1;
        alloc_first_i = 1'b0; alloc_second_i = 1'b0;
        cmt_alloc_first_i = 1'b0; cmt_alloc_second_i = 1'b0;
        free_first_valid_i = 1'b0; free_second_valid_i = 1'b0;
        flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        alloc_first_i = 1'b1; alloc_second_i = 1'b1;
        #4;
        check("rst.prd_first",  prd_first_o,  1);
        check("rst.prd_second", prd_second_o, 2);
        check("rst.count",      free_count_o, 63);
        check("rst.ok",         alloc_ok_o,   1);
        @(posedge clk); #1;
        rst = 1'b0;
        alloc_first_i = 1'b0; alloc_second_i = 1'b0;
    endtask

    // Drive one cycle, compare offers/counts against the model at mid-cycle,
    // then advance the model to what the next edge should produce.
    task automatic step(input bit a0, input bit a1, input bit c0, input bit c1,
                        input bit f0v, input int f0p, input bit f1v, input int f1p,
                        input bit fls, input string tag);
        bit ok;
        alloc_first_i       = a0;
        alloc_second_i      = a1;
        cmt_alloc_first_i   = c0;
        cmt_alloc_second_i  = c1;
        free_first_valid_i  = f0v;
        free_first_prd_i    = W'(f0p);
        free_second_valid_i = f1v;
        free_second_prd_i   = W'(f1p);
        flush_i             = fls;
        #4;
        check({tag, ".count"}, free_count_o, fl.size());
        check({tag, ".ok"}, alloc_ok_o, (fl.size() >= 2) ? 1 : 0);
        check({tag, ".inv"}, (free_count_o <= 63) ? 1 : 0, 1);
        if (fl.size() >= 1) check({tag, ".prd_first"}, prd_first_o, fl[0]);
        if (a0 && fl.size() >= 2)      check({tag, ".prd_second"}, prd_second_o, fl[1]);
        else if (!a0 && fl.size() >= 1) check({tag, ".prd_second"}, prd_second_o, fl[0]);

        ok = (fl.size() >= 2);
        repeat (int'(c0) + int'(c1)) begin
            if (uc.size() > 0) ret.push_back(uc.pop_front());
        end
        if (fls) begin
            while (uc.size() > 0) fl.push_front(uc.pop_back());
        end else if (ok) begin
            if (a0) uc.push_back(fl.pop_front());
            if (a1) uc.push_back(fl.pop_front());
        end
        if (f0v && f0p != 0) fl.push_back(f0p);
        if (f1v && f1p != 0) fl.push_back(f1p);
        @(posedge clk); #1;
    endtask

    initial begin
        bit a0, a1, c0, c1, f0v, f1v, fls;
        int f0p, f1p;

        // Reset state
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");

        // Drain: 31 dual allocations hand out 1..62 in order
        for (int i = 0; i < 31; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, "drain");
        check("drained.count", free_count_o, 1);
        check("drained.ok",    alloc_ok_o,   0);
        check("drained.prd",   prd_first_o,  63);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, "stall");
        check("stall.count", free_count_o, 1);

        // Free 5 and 9 while a (refused) allocation is requested
        step(1, 1, 0, 0, 1, 5, 1, 9, 0, "free59");
        check("free59.count", free_count_o, 3);
        check("free59.prd",   prd_first_o,  63);
        step(1, 1, 0, 0, 1, 20, 0, 0, 0, "alloc63_5");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, "alloc9_20");

        // Allocate 1..4, commit two, flush
        do_reset();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, "a12");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, "a34");
        step(0, 0, 1, 1, 0, 0, 0, 0, 1, "flush1");
        check("flush1.prd",   prd_first_o,  3);
        check("flush1.count", free_count_o, 61);

        // Flush together with dual alloc and a single commit
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, "a34b");
        step(1, 1, 1, 0, 0, 0, 0, 0, 1, "flush2");
        check("flush2.prd",   prd_first_o,  4);
        check("flush2.count", free_count_o, 60);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "postflush");

        // Tag 0 in slot 0 is dropped, tag 12 in slot 1 is pushed
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, "a4to13");
        check("pre0.count", free_count_o, 50);
        step(0, 0, 0, 0, 1, 0, 1, 12, 0, "free0_12");
        check("free0_12.count", free_count_o, 51);

        // Randomized traffic long enough to wrap every pointer several times
        do_reset();
        for (int cyc = 0; cyc < 260; cyc++) begin
            a0  = ($urandom_range(0, 3) != 0);
            a1  = ($urandom_range(0, 3) != 0);
            c0  = (uc.size() >= 1) && ($urandom_range(0, 3) != 0);
            c1  = c0 && (uc.size() >= 2) && ($urandom_range(0, 1) != 0);
            f0v = (ret.size() >= 1) && ($urandom_range(0, 2) != 0);
            f0p = f0v ? ret.pop_front() : 0;
            f1v = (ret.size() >= 1) && ($urandom_range(0, 2) != 0);
            f1p = f1v ? ret.pop_front() : 0;
            fls = ($urandom_range(0, 24) == 0);
            step(a0, a1, c0, c1, f0v, f0p, f1v, f1p, fls, "rand");
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
